buf_manager: RTL and testbench



---
 rtl/buf_manager_if.sv | 31 +++
 rtl/buf_manager.sv | 146 ++++++++++++++
 tb/tb_buf_manager.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/buf_manager_if.sv
// ============================================================================
// Module      : buf_manager_if
// Description : Wishbone slave bus bundle for the buffer-ID manager.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface buf_manager_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] wbs_address;
    logic [DATA_WIDTH-1:0] wbs_writedata;
    logic [DATA_WIDTH-1:0] wbs_readdata;
    logic                  wbs_strobe;
    logic                  wbs_cycle;
    logic                  wbs_write;
    logic                  wbs_ack;

    modport master (
        output wbs_address, wbs_writedata, wbs_strobe, wbs_cycle, wbs_write,
        input  wbs_readdata, wbs_ack
    );

    modport slave (
        input  wbs_address, wbs_writedata, wbs_strobe, wbs_cycle, wbs_write,
        output wbs_readdata, wbs_ack
    );
endinterface

`default_nettype wire

// File: rtl/buf_manager.sv
// ============================================================================
// Module      : buf_manager
// Description : Wishbone slave owning the image buffer-ID pool; read allocates,
//               write releases, with sticky exhaustion / bad-release status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module buf_manager #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BUFS   = 4,
    parameter int ID_WIDTH   = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    buf_manager_if.slave     wb,
    output logic [ID_WIDTH:0] free_count,
    output logic             ready
);

    localparam int                c_DEPTH   = 2 ** ID_WIDTH;
    localparam logic [ID_WIDTH-1:0] c_LAST_ID = ID_WIDTH'(NUM_BUFS - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [ID_WIDTH-1:0]   r_fifo [c_DEPTH];
    logic [ID_WIDTH-1:0]   r_rd_ptr;
    logic [ID_WIDTH-1:0]   r_wr_ptr;
    logic [ID_WIDTH-1:0]   r_init_id;
    logic [c_DEPTH-1:0]    r_alloc_map;
    logic [ID_WIDTH:0]     r_free_count;
    logic                  r_alloc_fail;
    logic                  r_bad_release;
    logic                  r_ready;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_readdata;

    logic                  w_req;
    logic [1:0]            w_offset;
    logic [ID_WIDTH-1:0]   w_rel_id;
    logic                  w_rel_ok;
    logic [ID_WIDTH-1:0]   w_head;
    logic [DATA_WIDTH-1:0] w_status;
    logic                  w_unused;

    function automatic logic [ID_WIDTH-1:0] f_next(input logic [ID_WIDTH-1:0] p);
        return (p == c_LAST_ID) ? '0 : p + ID_WIDTH'(1);
    endfunction

    assign w_req    = wb.wbs_cycle & wb.wbs_strobe & ~r_ack;
    assign w_offset = wb.wbs_address[3:2];
    assign w_rel_id = wb.wbs_writedata[ID_WIDTH-1:0];
    // Range check first so the bitmap lookup is only trusted for real IDs.
    assign w_rel_ok = (wb.wbs_writedata < DATA_WIDTH'(NUM_BUFS)) && r_alloc_map[w_rel_id];
    assign w_head   = r_fifo[r_rd_ptr];
    assign w_unused = ^{wb.wbs_address[ADDR_WIDTH-1:4], wb.wbs_address[1:0]};

    always_comb begin
        w_status        = '0;
        w_status[15:0]  = 16'(r_free_count);
        w_status[16]    = r_alloc_fail;
        w_status[17]    = r_bad_release;
        w_status[31]    = r_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_INIT;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_init_id     <= '0;
            r_alloc_map   <= '0;
            r_free_count  <= '0;
            r_alloc_fail  <= 1'b0;
            r_bad_release <= 1'b0;
            r_ready       <= 1'b0;
            r_ack         <= 1'b0;
            r_readdata    <= '0;
        end else begin
            r_ack      <= 1'b0;
            r_readdata <= '0;
            case (r_state)
                ST_INIT: begin
                    r_fifo[r_wr_ptr] <= r_init_id;
                    r_wr_ptr         <= f_next(r_wr_ptr);
                    r_free_count     <= r_free_count + 1'b1;
                    r_init_id        <= r_init_id + ID_WIDTH'(1);
                    if (r_init_id == c_LAST_ID) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_req) begin
                        r_ack <= 1'b1;
                        case (w_offset)
                            2'd0: begin
                                if (!wb.wbs_write) begin
                                    if (r_free_count != '0) begin
                                        r_readdata            <= DATA_WIDTH'(w_head);
                                        r_alloc_map[w_head]   <= 1'b1;
                                        r_rd_ptr              <= f_next(r_rd_ptr);
                                        r_free_count          <= r_free_count - 1'b1;
                                    end else begin
                                        r_readdata   <= '1;
                                        r_alloc_fail <= 1'b1;
                                    end
                                end else if (w_rel_ok) begin
                                    r_fifo[r_wr_ptr]      <= w_rel_id;
                                    r_wr_ptr              <= f_next(r_wr_ptr);
                                    r_alloc_map[w_rel_id] <= 1'b0;
                                    r_free_count          <= r_free_count + 1'b1;
                                end else begin
                                    r_bad_release <= 1'b1;
                                end
                            end
                            2'd1: begin
                                if (!wb.wbs_write) begin
                                    r_readdata <= w_status;
                                end else begin
                                    if (wb.wbs_writedata[16]) r_alloc_fail  <= 1'b0;
                                    if (wb.wbs_writedata[17]) r_bad_release <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign wb.wbs_ack      = r_ack;
    assign wb.wbs_readdata = r_readdata;
    assign free_count      = r_free_count;
    assign ready           = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_buf_manager.sv
// ============================================================================
// Module      : tb_buf_manager
// Description : Directed self-checking bench for buf_manager.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buf_manager;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] free_count;
    logic       ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buf_manager_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    buf_manager #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_BUFS  (4),
        .ID_WIDTH  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb        (bus.slave),
        .free_count(free_count),
        .ready     (ready)
    );

    // One bus transfer; returns latency in edges (-1 on timeout) and the bus state one cycle after the ack.
    task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int lat,
                           output logic ack_after, output logic [31:0] rd_after);
        bus.wbs_address   = addr;
        bus.wbs_write     = we;
        bus.wbs_writedata = wdata;
        bus.wbs_cycle     = 1'b1;
        bus.wbs_strobe    = 1'b1;
        lat   = -1;
        rdata = '0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack) begin
                lat   = i;
                rdata = bus.wbs_readdata;
                break;
            end
        end
        bus.wbs_strobe = 1'b0;
        bus.wbs_cycle  = 1'b0;
        bus.wbs_write  = 1'b0;
        @(posedge clk); #1;
        ack_after = bus.wbs_ack;
        rd_after  = bus.wbs_readdata;
    endtask

    logic [31:0] rd, rda;
    logic        aa;
    int          lat;

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", ready); end
        checks++; if (free_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", free_count); end
        checks++; if (bus.wbs_ack !== 1'b0 || bus.wbs_readdata !== 32'h0) begin
            errors++; $display("FAIL reset_bus got ack=%b rd=%h expected ack=0 rd=0", bus.wbs_ack, bus.wbs_readdata); end
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            checks++; if (ready !== (i == 4)) begin errors++; $display("FAIL init_ready[%0d] got %b expected %b", i, ready, (i == 4)); end
            checks++; if (free_count !== 3'(i)) begin errors++; $display("FAIL init_count[%0d] got %0d expected %0d", i, free_count, i); end
        end
    endtask

    task automatic test_alloc_all();
        for (int i = 0; i < 4; i++) begin
            wb_xfer(32'h0, 1'b0, 32'h0, rd, lat, aa, rda);
            checks++; if (rd !== 32'(i)) begin errors++; $display("FAIL alloc_id[%0d] got %h expected %h", i, rd, i); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL alloc_latency[%0d] got %0d expected 1", i, lat); end
            checks++; if (aa !== 1'b0 || rda !== 32'h0) begin
                errors++; $display("FAIL alloc_single_ack[%0d] got ack=%b rd=%h expected ack=0 rd=0", i, aa, rda); end
            checks++; if (free_count !== 3'(3 - i)) begin errors++; $display("FAIL alloc_count[%0d] got %0d expected %0d", i, free_count, 3 - i); end
        end
    endtask

    task automatic test_exhaust();
        wb_xfer(32'h0, 1'b0, 32'h0, rd, lat, aa, rda);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL exhaust_id got %h expected ffffffff", rd); end
        checks++; if (free_count !== 3'd0) begin errors++; $display("FAIL exhaust_count got %0d expected 0", free_count); end
        wb_xfer(32'h4, 1'b0, 32'h0, rd, lat, aa, rda);
        checks++; if (rd !== 32'h8001_0000) begin errors++; $display("FAIL exhaust_status got %h expected 80010000", rd); end
    endtask

    task automatic test_release_realloc();
        wb_xfer(32'h0, 1'b1, 32'd2, rd, lat, aa, rda);
        checks++; if (lat !== 1 || rd !== 32'h0) begin errors++; $display("FAIL release_ack got lat=%0d rd=%h expected lat=1 rd=0", lat, rd); end
        checks++; if (free_count !== 3'd1) begin errors++; $display("FAIL release_count got %0d expected 1", free_count); end
        wb_xfer(32'h0, 1'b0, 32'h0, rd, lat, aa, rda);
        checks++; if (rd !== 32'd2) begin errors++; $display("FAIL realloc_id got %h expected 2", rd); end
        checks++; if (free_count !== 3'd0) begin errors++; $display("FAIL realloc_count got %0d expected 0", free_count); end
        wb_xfer(32'h4, 1'b1, 32'h0001_0000, rd, lat, aa, rda);
        wb_xfer(32'h4, 1'b0, 32'h0, rd, lat, aa, rda);
        checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL clear_alloc_fail got %h expected 80000000", rd); end
    endtask

    task automatic test_bad_release();
        wb_xfer(32'h0, 1'b1, 32'd2, rd, lat, aa, rda);
        wb_xfer(32'h0, 1'b1, 32'd2, rd, lat, aa, rda);
        checks++; if (free_count !== 3'd1) begin errors++; $display("FAIL double_release_count got %0d expected 1", free_count); end
        wb_xfer(32'h0, 1'b1, 32'd7, rd, lat, aa, rda);
        checks++; if (lat !== 1) begin errors++; $display("FAIL bad_release_ack got lat=%0d expected 1", lat); end
        checks++; if (free_count !== 3'd1) begin errors++; $display("FAIL range_release_count got %0d expected 1", free_count); end
        wb_xfer(32'h4, 1'b0, 32'h0, rd, lat, aa, rda);
        checks++; if (rd !== 32'h8002_0001) begin errors++; $display("FAIL bad_release_status got %h expected 80020001", rd); end
        wb_xfer(32'h4, 1'b1, 32'h0002_0000, rd, lat, aa, rda);
        wb_xfer(32'h4, 1'b0, 32'h0, rd, lat, aa, rda);
        checks++; if (rd !== 32'h8000_0001) begin errors++; $display("FAIL clear_bad_release got %h expected 80000001", rd); end
    endtask

    task automatic test_fifo_order();
        logic [31:0] exp_ids [3];
        exp_ids[0] = 32'd2; exp_ids[1] = 32'd3; exp_ids[2] = 32'd0;
        wb_xfer(32'h0, 1'b1, 32'd3, rd, lat, aa, rda);
        wb_xfer(32'h0, 1'b1, 32'd0, rd, lat, aa, rda);
        checks++; if (free_count !== 3'd3) begin errors++; $display("FAIL order_count got %0d expected 3", free_count); end
        for (int i = 0; i < 3; i++) begin
            wb_xfer(32'h0, 1'b0, 32'h0, rd, lat, aa, rda);
            checks++; if (rd !== exp_ids[i]) begin errors++; $display("FAIL order_id[%0d] got %h expected %h", i, rd, exp_ids[i]); end
        end
        checks++; if (free_count !== 3'd0) begin errors++; $display("FAIL order_final_count got %0d expected 0", free_count); end
    endtask

    task automatic test_offsets();
        wb_xfer(32'h8, 1'b0, 32'h0, rd, lat, aa, rda);
        checks++; if (lat !== 1 || rd !== 32'h0) begin errors++; $display("FAIL offset2_read got lat=%0d rd=%h expected lat=1 rd=0", lat, rd); end
        wb_xfer(32'hC, 1'b1, 32'hFFFF_FFFF, rd, lat, aa, rda);
        checks++; if (lat !== 1) begin errors++; $display("FAIL offset3_write got lat=%0d expected 1", lat); end
        wb_xfer(32'h4, 1'b0, 32'h0, rd, lat, aa, rda);
        checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL offset_status got %h expected 80000000", rd); end
    endtask

    task automatic test_reset_mid();
        bus.wbs_address = 32'h0;
        bus.wbs_write   = 1'b0;
        bus.wbs_cycle   = 1'b1;
        bus.wbs_strobe  = 1'b1;
        reset           = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++; if (bus.wbs_ack !== 1'b0 || ready !== 1'b0) begin
                errors++; $display("FAIL midreset_no_ack got ack=%b ready=%b expected 0 0", bus.wbs_ack, ready); end
        end
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.wbs_ack !== 1'b0) begin errors++; $display("FAIL init_strobe_ack[%0d] got %b expected 0", i, bus.wbs_ack); end
        end
        checks++; if (ready !== 1'b1 || free_count !== 3'd4) begin
            errors++; $display("FAIL reinit got ready=%b count=%0d expected 1 4", ready, free_count); end
        @(posedge clk); #1;
        checks++; if (bus.wbs_ack !== 1'b1 || bus.wbs_readdata !== 32'h0) begin
            errors++; $display("FAIL reinit_alloc got ack=%b rd=%h expected 1 0", bus.wbs_ack, bus.wbs_readdata); end
        checks++; if (free_count !== 3'd3) begin errors++; $display("FAIL reinit_pop_count got %0d expected 3", free_count); end
        bus.wbs_strobe = 1'b0;
        bus.wbs_cycle  = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.wbs_ack !== 1'b0) begin errors++; $display("FAIL reinit_single_ack got %b expected 0", bus.wbs_ack); end
    endtask

    initial begin
        bus.wbs_address   = '0;
        bus.wbs_writedata = '0;
        bus.wbs_strobe    = 1'b0;
        bus.wbs_cycle     = 1'b0;
        bus.wbs_write     = 1'b0;
        test_reset();
        test_alloc_all();
        test_exhaust();
        test_release_realloc();
        test_bad_release();
        test_fifo_order();
        test_offsets();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
